// File: rtl/pc_ifid_stage.sv
// pc_ifid_stage: program counter and IF/ID pipeline register with stall, flush and statistics
module pc_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      somador_pc_plus_4,
  input  logic [31:0]      somador_branch_out,
  input  logic             branch_taken,
  input  logic             stall,
  input  logic [31:0]      instruction_in,
  output logic [31:0]      current_instruction_address,
  output logic [31:0]      somador_pc_plus_4_if_id,
  output logic [31:0]      instruction_if_id,
  output logic             valid_if_id,
  output logic             pc_misaligned,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, STALL, REDIRECT} state_t;
  state_t state, state_next;
  logic redirect;
  assign redirect = !stall && branch_taken;
  // next state: stall dominates, then redirect, otherwise normal fetch
  always_comb begin
    state_next = state;
    state_next = stall ? STALL : (branch_taken ? REDIRECT : RUN);
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end
  // PC, IF/ID fields and misalignment pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      current_instruction_address <= RESET_PC;
      instruction_if_id           <= NOP_INSTR;
      somador_pc_plus_4_if_id     <= '0;
      valid_if_id                 <= 1'b0;
      pc_misaligned               <= 1'b0;
    end else begin
      pc_misaligned <= redirect && (somador_branch_out[1:0] != 2'b00);
      if (redirect) begin
        current_instruction_address <= {somador_branch_out[31:2], 2'b00};
        instruction_if_id           <= NOP_INSTR;
        somador_pc_plus_4_if_id     <= '0;
        valid_if_id                 <= 1'b0;
      end else if (!stall) begin
        current_instruction_address <= somador_pc_plus_4;
        instruction_if_id           <= instruction_in;
        somador_pc_plus_4_if_id     <= somador_pc_plus_4;
        valid_if_id                 <= 1'b1;
      end
    end
  end
  // saturating flush and stall statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_count <= '0;
      stall_count <= '0;
    end else begin
      if (redirect && !(&flush_count)) flush_count <= flush_count + 1'b1;
      if (stall && !(&stall_count))    stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_ifid_stage.sv
// tb_pc_ifid_stage: directed plus random check of pc_ifid_stage against a rule-level model
module tb_pc_ifid_stage;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clock = 1'b0;
  logic reset, branch_taken, stall;
  logic [31:0] somador_pc_plus_4, somador_branch_out, instruction_in;
  logic [31:0] current_instruction_address, somador_pc_plus_4_if_id, instruction_if_id;
  logic valid_if_id, pc_misaligned;
  logic [CNT_W-1:0] flush_count, stall_count;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc, m_instr, m_p4;
  logic m_valid, m_mis;
  int m_fc, m_sc;

  pc_ifid_stage #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .somador_pc_plus_4(somador_pc_plus_4), .somador_branch_out(somador_branch_out),
    .branch_taken(branch_taken), .stall(stall), .instruction_in(instruction_in),
    .current_instruction_address(current_instruction_address),
    .somador_pc_plus_4_if_id(somador_pc_plus_4_if_id),
    .instruction_if_id(instruction_if_id), .valid_if_id(valid_if_id),
    .pc_misaligned(pc_misaligned), .flush_count(flush_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h2001_0005 + (a >> 2) * 32'h0001_0002;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, current_instruction_address, m_pc);
    chk({tag, ".instr"}, instruction_if_id, m_instr);
    chk({tag, ".p4"}, somador_pc_plus_4_if_id, m_p4);
    chk({tag, ".valid"}, {31'd0, valid_if_id}, {31'd0, m_valid});
    chk({tag, ".mis"}, {31'd0, pc_misaligned}, {31'd0, m_mis});
    chk({tag, ".fcnt"}, {{(32-CNT_W){1'b0}}, flush_count}, m_fc);
    chk({tag, ".scnt"}, {{(32-CNT_W){1'b0}}, stall_count}, m_sc);
  endtask

  // one clock: the adder and imem are emulated from the model's PC
  task automatic step(input string tag, input logic r, input logic s, input logic b,
                      input logic [31:0] bo);
    reset = r; stall = s; branch_taken = b; somador_branch_out = bo;
    somador_pc_plus_4 = m_pc + 32'd4;
    instruction_in = imem(m_pc);
    @(posedge clock);
    m_mis = 1'b0;
    if (r) begin
      m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_fc = 0; m_sc = 0;
    end else if (s) begin
      m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    end else if (b) begin
      m_pc = bo & ~32'd3;
      m_instr = 0; m_p4 = 0; m_valid = 0;
      m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      m_mis = (bo % 4) != 0;
    end else begin
      m_instr = imem(m_pc);
      m_pc = m_pc + 32'd4;
      m_p4 = m_pc;
      m_valid = 1;
    end
    #1 check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_mis = 0; m_fc = 0; m_sc = 0;
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    chk("rst_pc_const", current_instruction_address, 32'h0);
    step("adv1", 0, 0, 0, 0);
    chk("first_instr", instruction_if_id, 32'h2001_0005);
    step("adv2", 0, 0, 0, 0);
    chk("second_instr", instruction_if_id, 32'h2002_0007);
    chk("second_p4", somador_pc_plus_4_if_id, 32'h8);
    step("stl1", 0, 1, 0, 0);
    step("stl2", 0, 1, 0, 0);
    chk("stall_pc_held", current_instruction_address, 32'h8);
    chk("stall_cnt2", {28'd0, stall_count}, 32'd2);
    step("rel", 0, 0, 0, 0);
    chk("rel_pc", current_instruction_address, 32'hC);
    step("adv3", 0, 0, 0, 0);
    step("br40", 0, 0, 1, 32'h40);
    chk("br_pc", current_instruction_address, 32'h40);
    chk("br_flush", {28'd0, flush_count}, 32'd1);
    step("after_br", 0, 0, 0, 0);
    chk("after_br_valid", {31'd0, valid_if_id}, 32'd1);
    step("stl_br", 0, 1, 1, 32'h80);
    chk("stl_br_fcnt", {28'd0, flush_count}, 32'd1);
    step("br43", 0, 0, 1, 32'h43);
    chk("mis_pulse", {31'd0, pc_misaligned}, 32'd1);
    step("mis_clear", 0, 0, 0, 0);
    step("br_wrap", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0);
    chk("wrap_pc", current_instruction_address, 32'h0);
    step("br20", 0, 0, 1, 32'h20);
    step("stl20", 0, 1, 0, 0);
    step("rst_in_stall", 1, 1, 1, 32'h99);
    chk("rst_mid_stall_pc", current_instruction_address, 32'h0);
    for (int i = 0; i < 18; i++) step("sat_br", 0, 0, 1, 32'h100 + 32'(i * 4));
    chk("flush_sat", {28'd0, flush_count}, 32'd15);
    for (int i = 0; i < 18; i++) step("sat_stl", 0, 1, 0, 0);
    chk("stall_sat", {28'd0, stall_count}, 32'd15);
    step("rst_mid_redirect", 1, 0, 1, 32'h44);
    for (int i = 0; i < 400; i++)
      step("rnd", ($urandom_range(0, 60) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
